// File: rtl/datapath_pkg.sv
// Shared definitions for the datapath micro-sequencer: FSM states and
// the layout of the 33-bit instruction word that drives datapath1.
package datapath_pkg;

  localparam int INSTR_W    = 33;
  localparam int ALUSRC_BIT = 32;
  localparam int ADDSUB_BIT = 31;
  localparam int RA0_HI     = 30;
  localparam int RA0_LO     = 26;
  localparam int RA1_HI     = 25;
  localparam int RA1_LO     = 21;
  localparam int WA_HI      = 20;
  localparam int WA_LO      = 16;
  localparam int IM_HI      = 15;
  localparam int IM_LO      = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // Word presented whenever no instruction is issuing: a harmless write to a scratch register.
  function automatic logic [INSTR_W-1:0] idle_word(input logic [4:0] wa);
    return {1'b0, 1'b0, 5'd0, 5'd0, wa, 16'd0};
  endfunction

endpackage

// File: rtl/seq_prog_buf.sv
// Program buffer: DEPTH x 33 register file, synchronous write,
// combinational read, synchronous clear.
module seq_prog_buf
  import datapath_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               i_CLK,
  input  logic               i_clr,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  logic [INSTR_W-1:0] i_wdata,
  input  logic [AW-1:0]      i_raddr,
  output logic [INSTR_W-1:0] o_rdata
);

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [INSTR_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (i_we) mem_d[i_waddr] = i_wdata;
  end

  always_ff @(posedge i_CLK) begin
    if (i_clr) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/datapath_sequencer.sv
// Micro-sequencer replaying a small program buffer onto the datapath1
// control inputs, one word per cycle or one per i_Go in step mode.
module datapath_sequencer
  import datapath_pkg::*;
#(
  parameter int         DEPTH   = 8,
  parameter logic [4:0] IDLE_WA = 5'd0,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               i_CLK,
  input  logic               i_RST,
  input  logic               i_LoadEn,
  input  logic [AW-1:0]      i_LoadAddr,
  input  logic [INSTR_W-1:0] i_LoadData,
  input  logic               i_Start,
  input  logic [AW:0]        i_Len,
  input  logic               i_Step,
  input  logic               i_Go,
  input  logic               i_HaltOnOvf,
  input  logic               i_Abort,
  input  logic [31:0]        i_ALUout,
  input  logic               i_Cout,
  input  logic               i_Overflow,
  output logic               o_ALUSrc,
  output logic               o_AddSub,
  output logic [4:0]         o_RA0,
  output logic [4:0]         o_RA1,
  output logic [4:0]         o_WA,
  output logic [15:0]        o_Im,
  output logic               o_Busy,
  output logic               o_Done,
  output logic               o_Fault,
  output logic [AW-1:0]      o_PC,
  output logic [31:0]        o_Result,
  output logic               o_Cout,
  output logic               o_OvfSticky
);

  seq_state_e         state_q, state_d;
  logic [AW-1:0]      pc_q, pc_d;
  logic [AW:0]        len_q, len_d;
  logic               step_q, step_d;
  logic               halt_q, halt_d;
  logic [31:0]        result_q, result_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               fault_q, fault_d;

  logic [AW:0]        len_clip;
  logic               last_instr;
  logic [INSTR_W-1:0] rd_word;
  logic [INSTR_W-1:0] ctrl;

  seq_prog_buf #(.DEPTH(DEPTH)) u_buf (
    .i_CLK   (i_CLK),
    .i_clr   (i_RST),
    .i_we    (i_LoadEn && (state_q == ST_IDLE)),
    .i_waddr (i_LoadAddr),
    .i_wdata (i_LoadData),
    .i_raddr (pc_q),
    .o_rdata (rd_word)
  );

  assign len_clip   = (i_Len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : i_Len;
  assign last_instr = ({1'b0, pc_q} == (len_q - 1'b1));

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    len_d    = len_q;
    step_d   = step_q;
    halt_d   = halt_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    fault_d  = fault_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_Start) begin
          if (len_clip == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            pc_d    = '0;
            len_d   = len_clip;
            step_d  = i_Step;
            halt_d  = i_HaltOnOvf;
            ovf_d   = 1'b0;
            fault_d = 1'b0;
          end
        end
      end
      ST_RUN: begin
        result_d = i_ALUout;
        cout_d   = i_Cout;
        ovf_d    = ovf_q | i_Overflow;
        if (halt_q && i_Overflow) begin
          state_d = ST_DONE;
          fault_d = 1'b1;
        end else if (last_instr) begin
          state_d = ST_DONE;
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = step_q ? ST_PAUSE : ST_RUN;
        end
      end
      ST_PAUSE: if (i_Go) state_d = ST_RUN;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Abort wins, but the RUN-cycle capture above still lands; a halt fault is not reported.
    if (i_Abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      fault_d = fault_q;
    end
    if (state_d == ST_IDLE) pc_d = '0;
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      len_q    <= '0;
      step_q   <= 1'b0;
      halt_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      len_q    <= len_d;
      step_q   <= step_d;
      halt_q   <= halt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      fault_q  <= fault_d;
    end
  end

  assign ctrl = (state_q == ST_RUN) ? rd_word : idle_word(IDLE_WA);

  assign o_ALUSrc    = ctrl[ALUSRC_BIT];
  assign o_AddSub    = ctrl[ADDSUB_BIT];
  assign o_RA0       = ctrl[RA0_HI:RA0_LO];
  assign o_RA1       = ctrl[RA1_HI:RA1_LO];
  assign o_WA        = ctrl[WA_HI:WA_LO];
  assign o_Im        = ctrl[IM_HI:IM_LO];
  assign o_Busy      = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign o_Done      = (state_q == ST_DONE);
  assign o_Fault     = fault_q;
  assign o_PC        = pc_q;
  assign o_Result    = result_q;
  assign o_Cout      = cout_q;
  assign o_OvfSticky = ovf_q;

endmodule
